// File: rtl/fir_pkg.sv
// Shared widths and limits for the FIR filter and its decimating output stage.
package fir_pkg;

  localparam int FIR_OUT_W  = 16;
  localparam int SAMPLE_W   = 8;
  localparam int SAMPLE_MAX = 127;
  localparam int SAMPLE_MIN = -128;

endpackage : fir_pkg

// File: rtl/fir_decim_fifo_sync_fifo.sv
// Show-ahead synchronous FIFO: storage, wrapping pointers, occupancy and full/empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rd_data_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             do_push, do_pop;

  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);

  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    level_d = level_q + LW'(do_push) - LW'(do_pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign level_o   = level_q;

endmodule : sync_fifo

// File: rtl/fir_decim_fifo.sv
// FIR output stage: decimate, round/scale, saturate to 8 bits and buffer for a valid/ready consumer.
module fir_decim_fifo
  import fir_pkg::*;
#(
  parameter int DECIM = 4,
  parameter int SHIFT = 4,
  parameter int DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_en,
  input  logic signed [FIR_OUT_W-1:0] y_in,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic signed [SAMPLE_W-1:0]  m_data,
  output logic [$clog2(DEPTH):0]      level,
  output logic                        sat,
  output logic                        ovf,
  input  logic                        clr_flags
);

  localparam int PH_W = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int EXT_W = FIR_OUT_W + 1;
  // Half an output LSB; collapses to zero when no scaling is applied.
  localparam int RND = (1 << SHIFT) >> 1;

  logic [PH_W-1:0]          ph_q, ph_d;
  logic                     sat_q, sat_d;
  logic                     ovf_q, ovf_d;
  logic                     kept;
  logic signed [EXT_W-1:0]  y_ext, y_rnd, t;
  logic                     clip_hi, clip_lo, clip;
  logic [SAMPLE_W-1:0]      sample;
  logic                     push, pop;
  logic                     fifo_full, fifo_empty;
  logic [SAMPLE_W-1:0]      fifo_rd_data;

  assign kept = in_en && (ph_q == '0);

  always_comb begin
    ph_d = ph_q;
    if (in_en) begin
      if (ph_q == PH_W'(DECIM - 1)) ph_d = '0;
      else                          ph_d = ph_q + 1'b1;
    end
  end

  assign y_ext   = {y_in[FIR_OUT_W-1], y_in};
  assign y_rnd   = y_ext + EXT_W'(RND);
  assign t       = y_rnd >>> SHIFT;
  assign clip_hi = (t > $signed(EXT_W'(SAMPLE_MAX)));
  assign clip_lo = (t < $signed(EXT_W'(SAMPLE_MIN)));
  assign clip    = clip_hi || clip_lo;

  always_comb begin
    sample = t[SAMPLE_W-1:0];
    if (clip_hi)      sample = SAMPLE_W'(SAMPLE_MAX);
    else if (clip_lo) sample = SAMPLE_W'(SAMPLE_MIN);
  end

  assign pop  = m_valid && m_ready;
  assign push = kept && (!fifo_full || pop);

  // A flag-setting event in the same cycle as clr_flags keeps the flag set.
  always_comb begin
    sat_d = sat_q && !clr_flags;
    ovf_d = ovf_q && !clr_flags;
    if (kept && clip)              sat_d = 1'b1;
    if (kept && fifo_full && !pop) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ph_q  <= '0;
      sat_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      ph_q  <= ph_d;
      sat_q <= sat_d;
      ovf_q <= ovf_d;
    end
  end

  sync_fifo #(
    .WIDTH (SAMPLE_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_i    (push),
    .wr_data_i (sample),
    .pop_i     (pop),
    .rd_data_o (fifo_rd_data),
    .level_o   (level),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  assign m_valid = !fifo_empty;
  assign m_data  = fifo_rd_data;
  assign sat     = sat_q;
  assign ovf     = ovf_q;

endmodule : fir_decim_fifo

// File: tb/tb_fir_decim_fifo.sv
// Bench: DECIM=1 and DECIM=4 instances; vector table, corner sequences and a randomized model run.
module tb_fir_decim_fifo;

  localparam int SHIFTV = 4;
  localparam int DEPTHV = 8;
  localparam int DEC4   = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic               en1, mr1, clr1, v1, s1, o1;
  logic signed [15:0] y1;
  logic signed [7:0]  d1;
  logic [3:0]         lv1;
  logic               en4, mr4, clr4, v4, s4, o4;
  logic signed [15:0] y4;
  logic signed [7:0]  d4;
  logic [3:0]         lv4;

  fir_decim_fifo #(.DECIM(1), .SHIFT(SHIFTV), .DEPTH(DEPTHV)) dut_d1 (
    .clk(clk), .rst(rst), .in_en(en1), .y_in(y1), .m_valid(v1), .m_ready(mr1),
    .m_data(d1), .level(lv1), .sat(s1), .ovf(o1), .clr_flags(clr1));

  fir_decim_fifo #(.DECIM(DEC4), .SHIFT(SHIFTV), .DEPTH(DEPTHV)) dut_d4 (
    .clk(clk), .rst(rst), .in_en(en4), .y_in(y4), .m_valid(v4), .m_ready(mr4),
    .m_data(d4), .level(lv4), .sat(s4), .ovf(o4), .clr_flags(clr4));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    en1 = 0; mr1 = 0; clr1 = 0; y1 = '0;
    en4 = 0; mr4 = 0; clr4 = 0; y4 = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    tick();
    rst = 0;
  endtask

  task automatic chk_queue(input string nm, input int got[$], input int exp[$]);
    chk({nm, "_count"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      chk(nm, got[i], exp[i]);
  endtask

  // Reference conversion from the arithmetic definition: floor((y + half) / 2^S), then clamp.
  function automatic int fdiv(input int n, input int d);
    if (n >= 0) return n / d;
    return -((-n + d - 1) / d);
  endfunction

  function automatic int conv(input int y, output bit clipped);
    int t;
    t = fdiv(y + ((1 << SHIFTV) / 2), 1 << SHIFTV);
    clipped = (t > 127) || (t < -128);
    if (t > 127)  t = 127;
    if (t < -128) t = -128;
    return t;
  endfunction

  int  mq[$];
  int  mcnt;
  bit  msat, movf;

  task automatic model_step(input bit en, input int y, input bit mr, input bit clr);
    bit pop, kept, clipped, accept;
    int val;
    pop  = (mq.size() > 0) && mr;
    kept = en && (mcnt == 0);
    if (en) mcnt = (mcnt + 1) % DEC4;
    val    = conv(y, clipped);
    accept = kept && ((mq.size() < DEPTHV) || pop);
    if (pop)    void'(mq.pop_front());
    if (accept) mq.push_back(val);
    if (clr) begin msat = 0; movf = 0; end
    if (kept && clipped) msat = 1;
    if (kept && !accept) movf = 1;
  endtask

  typedef struct {
    logic signed [15:0] y;
    int                 exp_d;
    bit                 exp_s;
  } vec_t;

  vec_t tbl[10];
  int   got[$];
  int   expq[$];

  initial begin
    tbl[0] = '{16'sd24,    2,    1'b0};
    tbl[1] = '{-16'sd24,   -1,   1'b0};
    tbl[2] = '{16'sd7,     0,    1'b0};
    tbl[3] = '{16'sd4000,  127,  1'b1};
    tbl[4] = '{16'sd0,     0,    1'b0};
    tbl[5] = '{-16'sd4000, -128, 1'b1};
    tbl[6] = '{16'sd2039,  127,  1'b0};
    tbl[7] = '{16'sd2040,  127,  1'b1};
    tbl[8] = '{-16'sd2056, -128, 1'b0};
    tbl[9] = '{-16'sd2057, -128, 1'b1};

    idle_inputs();
    rst = 1;
    #12;
    chk("rst_valid_d1", v1, 0);  chk("rst_level_d1", lv1, 0);
    chk("rst_sat_d1", s1, 0);    chk("rst_ovf_d1", o1, 0);
    chk("rst_valid_d4", v4, 0);  chk("rst_level_d4", lv4, 0);
    rst = 0;
    tick();

    // Round/saturate table; clr_flags is pulsed with each sample so sat reflects this sample only.
    for (int i = 0; i < 10; i++) begin
      en1 = 1; y1 = tbl[i].y; clr1 = 1; mr1 = 0;
      tick();
      chk("tbl_level", lv1, 1);
      chk("tbl_data", d1, tbl[i].exp_d);
      chk("tbl_sat", s1, tbl[i].exp_s);
      en1 = 0; clr1 = 0; mr1 = 1;
      tick();
      chk("tbl_drain_level", lv1, 0);
    end
    mr1 = 0; clr1 = 1;
    tick();
    chk("clr_sat", s1, 0);
    clr1 = 0;

    // Overflow: nine pushes into an eight-entry FIFO with the consumer stalled.
    do_reset();
    for (int i = 1; i <= 9; i++) begin
      en1 = 1; y1 = 16'(i * 16);
      tick();
      if (i == 8) begin
        chk("ovf_level8", lv1, 8);
        chk("ovf_flag8", o1, 0);
      end
    end
    chk("ovf_level9", lv1, 8);
    chk("ovf_flag9", o1, 1);
    en1 = 0; mr1 = 1;
    got.delete(); expq.delete();
    for (int i = 0; i < 10; i++) begin
      if (v1 && mr1) got.push_back(int'(d1));
      tick();
    end
    for (int i = 1; i <= 8; i++) expq.push_back(i);
    chk_queue("ovf_drain", got, expq);
    chk("ovf_drained_level", lv1, 0);

    // Full FIFO with a simultaneous pop and kept sample.
    mr1 = 0; clr1 = 1;
    tick();
    clr1 = 0;
    chk("full_pop_ovf_clr", o1, 0);
    for (int i = 1; i <= 8; i++) begin
      en1 = 1; y1 = 16'(i * 16);
      tick();
    end
    chk("full_pop_pre_level", lv1, 8);
    got.delete(); expq.delete();
    en1 = 1; y1 = 16'sd160; mr1 = 1;
    if (v1 && mr1) got.push_back(int'(d1));
    tick();
    chk("full_pop_level", lv1, 8);
    chk("full_pop_ovf", o1, 0);
    en1 = 0;
    for (int i = 0; i < 10; i++) begin
      if (v1 && mr1) got.push_back(int'(d1));
      tick();
    end
    for (int i = 1; i <= 8; i++) expq.push_back(i);
    expq.push_back(10);
    chk_queue("full_pop_order", got, expq);
    mr1 = 0;

    // Decimation by four, back to back and then with in_en gaps carrying junk data.
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      got.delete();
      mr4 = 1;
      for (int i = 1; i <= 9; i++) begin
        if (pass == 1) begin
          for (int g = 0; g < int'($urandom_range(1, 3)); g++) begin
            en4 = 0; y4 = 16'($urandom);
            if (v4 && mr4) got.push_back(int'(d4));
            tick();
          end
        end
        en4 = 1; y4 = 16'(i * 16);
        if (v4 && mr4) got.push_back(int'(d4));
        tick();
      end
      en4 = 0;
      for (int i = 0; i < 4; i++) begin
        if (v4 && mr4) got.push_back(int'(d4));
        tick();
      end
      expq = '{1, 5, 9};
      chk_queue(pass == 0 ? "decim_contig" : "decim_gaps", got, expq);
    end

    // Asynchronous reset between edges with five samples buffered and ph mid-count.
    do_reset();
    for (int i = 0; i < 18; i++) begin
      en4 = 1; y4 = (i == 0) ? 16'sd4000 : 16'(i * 16);
      tick();
    end
    chk("mid_level5", lv4, 5);
    chk("mid_sat_set", s4, 1);
    en4 = 0;
    #2 rst = 1;
    #1;
    chk("mid_rst_valid", v4, 0);
    chk("mid_rst_level", lv4, 0);
    chk("mid_rst_sat", s4, 0);
    chk("mid_rst_ovf", o4, 0);
    #1 rst = 0;
    en4 = 1; y4 = 16'sd48;
    tick();
    chk("mid_first_kept_level", lv4, 1);
    chk("mid_first_kept_data", d4, 3);
    y4 = 16'sd80;
    tick();
    chk("mid_second_dropped_by_decim", lv4, 1);

    // Randomized run on the DECIM=4 instance against the queue model.
    do_reset();
    mq.delete(); mcnt = 0; msat = 0; movf = 0;
    for (int c = 0; c < 3000; c++) begin
      en4  = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 3) == 0) y4 = 16'($urandom);
      else                           y4 = 16'(int'($urandom_range(0, 4200)) - 2100);
      mr4  = ((c / 500) % 2 == 0) ? ($urandom_range(0, 9) < 2) : ($urandom_range(0, 9) < 8);
      clr4 = ($urandom_range(0, 29) == 0);
      model_step(en4, int'(y4), mr4, clr4);
      tick();
      chk("rnd_valid", v4, int'(mq.size() != 0));
      chk("rnd_level", lv4, mq.size());
      chk("rnd_sat", s4, msat);
      chk("rnd_ovf", o4, movf);
      if (mq.size() > 0) chk("rnd_data", d4, mq[0]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_fir_decim_fifo
